// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, slave word
// addresses and the default build-time expected values.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LAT  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd4919;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1737994685;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// publishes a registered pass/fail verdict against build-time constants.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        pass
);

  localparam logic [1:0]  LAT_LAST   = READ_LATENCY[1:0];
  localparam logic [15:0] WAIT_LIMIT = TIMEOUT_CYCLES[15:0];

  sysid_chk_state_t state_r;
  logic        sel_r;
  logic        m_read_r;
  logic        busy_r;
  logic        done_r;
  logic        id_ok_r;
  logic        ts_ok_r;
  logic        timeout_r;
  logic        pass_r;
  logic        started_r;
  logic [1:0]  lat_cnt_r;
  logic [15:0] wait_cnt_r;
  logic [31:0] id_value_r;
  logic [31:0] ts_value_r;

  logic        launch_s;
  logic        capture_s;
  logic [15:0] wait_inc_s;

  // Launch, capture-strobe and saturating wait-count decode
  always_comb begin
    launch_s   = 1'b0;
    capture_s  = 1'b0;
    wait_inc_s = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : (wait_cnt_r + 16'd1);
    case (state_r)
      IDLE: begin
        if (start || (AUTO_START && !started_r)) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      REQ: begin
        if (!m_waitrequest && (READ_LATENCY == 0)) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      LAT: begin
        if (lat_cnt_r == LAT_LAST) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      DONE: begin
        if (start) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      default: begin
        launch_s  = 1'b0;
        capture_s = 1'b0;
      end
    endcase
  end

  // Captured words: cleared on every new check, written by the read in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
    end else if (launch_s) begin
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
    end else if (capture_s) begin
      if (sel_r == SYSID_ADDR_ID) begin
        id_value_r <= m_readdata;
      end else begin
        ts_value_r <= m_readdata;
      end
    end
  end

  // Read sequencer and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      sel_r      <= SYSID_ADDR_ID;
      m_read_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      timeout_r  <= 1'b0;
      pass_r     <= 1'b0;
      started_r  <= 1'b0;
      lat_cnt_r  <= 2'd0;
      wait_cnt_r <= 16'd0;
    end else if (launch_s) begin
      state_r    <= REQ;
      sel_r      <= SYSID_ADDR_ID;
      m_read_r   <= 1'b1;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      timeout_r  <= 1'b0;
      pass_r     <= 1'b0;
      started_r  <= 1'b1;
      lat_cnt_r  <= 2'd0;
      wait_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        REQ: begin
          if (m_waitrequest) begin
            if (wait_inc_s >= WAIT_LIMIT) begin
              // Abandon the whole check; the TS read is never issued
              timeout_r  <= 1'b1;
              m_read_r   <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              wait_cnt_r <= 16'd0;
              state_r    <= DONE;
            end else begin
              wait_cnt_r <= wait_inc_s;
            end
          end else begin
            wait_cnt_r <= 16'd0;
            if (capture_s) begin
              if (sel_r == SYSID_ADDR_ID) begin
                sel_r <= SYSID_ADDR_TS;
              end else begin
                m_read_r <= 1'b0;
                state_r  <= CMP;
              end
            end else begin
              m_read_r  <= 1'b0;
              lat_cnt_r <= 2'd1;
              state_r   <= LAT;
            end
          end
        end
        LAT: begin
          if (capture_s) begin
            if (sel_r == SYSID_ADDR_ID) begin
              sel_r    <= SYSID_ADDR_TS;
              m_read_r <= 1'b1;
              state_r  <= REQ;
            end else begin
              state_r <= CMP;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        CMP: begin
          id_ok_r <= word_match(id_value_r, EXPECTED_ID);
          ts_ok_r <= word_match(ts_value_r, EXPECTED_TS);
          pass_r  <= word_match(id_value_r, EXPECTED_ID) &&
                     word_match(ts_value_r, EXPECTED_TS) && !timeout_r;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        IDLE, DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r  <= IDLE;
          m_read_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign m_address = sel_r;
  assign m_read    = m_read_r;
  assign id_value  = id_value_r;
  assign ts_value  = ts_value_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign id_ok     = id_ok_r;
  assign ts_ok     = ts_ok_r;
  assign timeout   = timeout_r;
  assign pass      = pass_r;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: instance A uses a zero-latency slave, instance B a
// two-cycle-latency slave with waitrequest stalls and a short timeout.
module tb_sysid_checker;

  localparam logic [31:0] ID_W  = 32'd4919;
  localparam logic [31:0] TS_W  = 32'd1737994685;
  localparam logic [31:0] JUNK  = 32'hDEADBEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: READ_LATENCY=0, no stalls
  logic        reset_n_a = 1'b0;
  logic        start_a   = 1'b0;
  logic [31:0] id_word_a = ID_W;
  logic        addr_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a, pass_a;
  logic [31:0] rdata_a, id_a, ts_a;
  assign rdata_a = addr_a ? TS_W : id_word_a;

  sysid_checker u_a (
    .clock(clock), .reset_n(reset_n_a), .start(start_a),
    .m_address(addr_a), .m_read(read_a), .m_waitrequest(1'b0),
    .m_readdata(rdata_a), .id_value(id_a), .ts_value(ts_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
    .timeout(to_a), .pass(pass_a)
  );

  // Instance B: READ_LATENCY=2, 3 stall cycles per read (or stuck), timeout 8
  logic        reset_n_b = 1'b0;
  logic        start_b   = 1'b0;
  logic        stuck_b   = 1'b0;
  int          wr_cnt    = 0;
  logic [31:0] pipe1 = JUNK, pipe2 = JUNK;
  logic        addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b, pass_b, wait_b;
  logic [31:0] id_b, ts_b;
  assign wait_b = stuck_b || (read_b && (wr_cnt < 3));

  always @(posedge clock) begin
    wr_cnt <= (!read_b || !wait_b) ? 0 : wr_cnt + 1;
    pipe2  <= pipe1;
    pipe1  <= (read_b && !wait_b) ? (addr_b ? TS_W : ID_W) : JUNK;
  end

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8)) u_b (
    .clock(clock), .reset_n(reset_n_b), .start(start_b),
    .m_address(addr_b), .m_read(read_b), .m_waitrequest(wait_b),
    .m_readdata(pipe2), .id_value(id_b), .ts_value(ts_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
    .timeout(to_b), .pass(pass_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [13:0] rd_pat;

  initial begin
    // Reset state
    @(negedge clock);
    chk("a_rst_read", {31'd0, read_a}, 32'd0);
    chk("a_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("a_rst_done", {31'd0, done_a}, 32'd0);
    chk("a_rst_pass", {31'd0, pass_a}, 32'd0);
    chk("a_rst_id", id_a, 32'd0);

    // Auto-start after release, zero-latency slave
    reset_n_a = 1'b1;
    step();
    chk("a_c1_read", {31'd0, read_a}, 32'd1);
    chk("a_c1_addr", {31'd0, addr_a}, 32'd0);
    chk("a_c1_busy", {31'd0, busy_a}, 32'd1);
    step();
    chk("a_c2_read", {31'd0, read_a}, 32'd1);
    chk("a_c2_addr", {31'd0, addr_a}, 32'd1);
    chk("a_c2_id", id_a, ID_W);
    step();
    chk("a_c3_read", {31'd0, read_a}, 32'd0);
    chk("a_c3_done", {31'd0, done_a}, 32'd0);
    step();
    chk("a_c4_done", {31'd0, done_a}, 32'd1);
    chk("a_c4_busy", {31'd0, busy_a}, 32'd0);
    chk("a_c4_pass", {31'd0, pass_a}, 32'd1);
    chk("a_c4_id", id_a, ID_W);
    chk("a_c4_ts", ts_a, TS_W);

    // Wrong ID word
    id_word_a = 32'd4920;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_bad_clr_done", {31'd0, done_a}, 32'd0);
    chk("a_bad_clr_pass", {31'd0, pass_a}, 32'd0);
    repeat (3) step();
    chk("a_bad_done", {31'd0, done_a}, 32'd1);
    chk("a_bad_idok", {31'd0, id_ok_a}, 32'd0);
    chk("a_bad_tsok", {31'd0, ts_ok_a}, 32'd1);
    chk("a_bad_pass", {31'd0, pass_a}, 32'd0);
    chk("a_bad_id", id_a, 32'd4920);

    // Start while busy is ignored
    id_word_a = ID_W;
    start_a = 1'b1;
    step();
    chk("a_busy_addr0", {31'd0, addr_a}, 32'd0);
    step();
    chk("a_busy_addr1", {31'd0, addr_a}, 32'd1);
    step();
    start_a = 1'b0;
    chk("a_busy_cmp", {31'd0, read_a}, 32'd0);
    step();
    chk("a_busy_done", {31'd0, done_a}, 32'd1);
    chk("a_busy_pass", {31'd0, pass_a}, 32'd1);
    step();
    chk("a_busy_norun_read", {31'd0, read_a}, 32'd0);
    chk("a_busy_norun_done", {31'd0, done_a}, 32'd1);

    // Reset during the TS read, then automatic rerun
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    chk("a_mid_ts_read", {31'd0, read_a}, 32'd1);
    chk("a_mid_ts_addr", {31'd0, addr_a}, 32'd1);
    #2 reset_n_a = 1'b0;
    #1;
    chk("a_mid_rst_read", {31'd0, read_a}, 32'd0);
    chk("a_mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("a_mid_rst_id", id_a, 32'd0);
    @(negedge clock);
    reset_n_a = 1'b1;
    step();
    chk("a_rerun_read", {31'd0, read_a}, 32'd1);
    repeat (3) step();
    chk("a_rerun_done", {31'd0, done_a}, 32'd1);
    chk("a_rerun_pass", {31'd0, pass_a}, 32'd1);

    // Instance B: latency 2 with 3 stall cycles per read
    reset_n_b = 1'b1;
    rd_pat = 14'b0000_1111_00_1111;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("b_read_c%0d", i + 1), {31'd0, read_b}, {31'd0, rd_pat[i]});
      if (rd_pat[i]) begin
        chk($sformatf("b_addr_c%0d", i + 1), {31'd0, addr_b}, (i < 6) ? 32'd0 : 32'd1);
      end
      chk($sformatf("b_done_c%0d", i + 1), {31'd0, done_b}, (i == 13) ? 32'd1 : 32'd0);
      if (i == 5) chk("b_id_early", id_b, 32'd0);
      if (i == 6) chk("b_id_capt", id_b, ID_W);
      if (i == 11) chk("b_ts_early", ts_b, 32'd0);
    end
    chk("b_pass", {31'd0, pass_b}, 32'd1);
    chk("b_ts", ts_b, TS_W);

    // Instance B: waitrequest stuck, timeout after 8 wait cycles
    stuck_b = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_to_clr_done", {31'd0, done_b}, 32'd0);
    chk("b_to_read0", {31'd0, read_b}, 32'd1);
    repeat (7) step();
    chk("b_to_read7", {31'd0, read_b}, 32'd1);
    chk("b_to_not_yet", {31'd0, to_b}, 32'd0);
    step();
    chk("b_to_flag", {31'd0, to_b}, 32'd1);
    chk("b_to_read_off", {31'd0, read_b}, 32'd0);
    chk("b_to_done", {31'd0, done_b}, 32'd1);
    chk("b_to_pass", {31'd0, pass_b}, 32'd0);
    chk("b_to_idok", {31'd0, id_ok_b}, 32'd0);
    repeat (3) step();
    chk("b_to_no_ts_read", {31'd0, read_b}, 32'd0);
    chk("b_to_no_ts_addr", {31'd0, addr_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
